// File: rtl/keycode_note_decoder.sv
// keycode_note_decoder: turns a stream of PS/2 set-2 scan bytes into a
// monophonic note selection with last-pressed priority. It outputs the speaker
// half-period count, a note-active flag, the note index, and an error pulse for
// malformed prefix sequences.
// Optional feature macro: OCTAVE_SHIFT_EN. When it is defined, Z (1A) and
// X (22) shift the octave down or up within -1..+1.
module keycode_note_decoder #(
    parameter int COUNT_W  = 20,
    parameter int NUM_KEYS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [7:0]         key_byte,
    output logic [COUNT_W-1:0] half_period,
    output logic               note_on,
    output logic [2:0]         note_idx,
    output logic               key_err
);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;

    // Scan codes for note keys, index 0 (C4) in the low byte.
    localparam logic [8*8-1:0] KEY_CODES = {8'h42, 8'h3B, 8'h33, 8'h34,
                                            8'h2B, 8'h23, 8'h1B, 8'h1C};

    state_t              state_reg, state_next;
    logic [NUM_KEYS-1:0] mask_reg, mask_next;
    logic [2:0]          idx_next;
    logic                on_next;
    logic [COUNT_W-1:0]  hp_next;
    logic                err_next;
    logic                make_ev, brk_ev;
    logic [NUM_KEYS-1:0] key_match;
    logic                key_mapped;
    logic [2:0]          key_idx;
    logic                is_prefix;

`ifdef OCTAVE_SHIFT_EN
    // Octave offset encoding: 2'b00 = 0, 2'b01 = +1 (higher pitch), 2'b11 = -1.
    logic [1:0] oct_reg, oct_next;
`endif

    // One comparator per note key.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_match
            assign key_match[gi] = (key_byte == KEY_CODES[gi*8 +: 8]);
        end
    endgenerate

    assign key_mapped = |key_match;
    assign is_prefix  = (key_byte == BREAK_PREFIX) || (key_byte == EXT_PREFIX);

    // Base half-period table, in clk cycles at 100 MHz.
    function automatic logic [COUNT_W-1:0] base_hp(input logic [2:0] idx);
        logic [COUNT_W-1:0] hp;
        case (idx)
            3'd0:    hp = COUNT_W'(191109);
            3'd1:    hp = COUNT_W'(170265);
            3'd2:    hp = COUNT_W'(151685);
            3'd3:    hp = COUNT_W'(143172);
            3'd4:    hp = COUNT_W'(127550);
            3'd5:    hp = COUNT_W'(113636);
            3'd6:    hp = COUNT_W'(101238);
            default: hp = COUNT_W'(95556);
        endcase
        return hp;
    endfunction

    // Index of the highest set bit of a held-key mask.
    function automatic logic [2:0] highest_held(input logic [NUM_KEYS-1:0] m);
        logic [2:0] h;
        h = 3'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (m[i]) h = 3'(i);
        end
        return h;
    endfunction

    // Encode the one-hot key match into a note index.
    always_comb begin
        key_idx = 3'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_match[i]) key_idx = 3'(i);
        end
    end

    // Prefix decoder, held-key mask update and note selection.
    always_comb begin
        state_next = state_reg;
        mask_next  = mask_reg;
        idx_next   = note_idx;
        err_next   = 1'b0;
        make_ev    = 1'b0;
        brk_ev     = 1'b0;
`ifdef OCTAVE_SHIFT_EN
        oct_next   = oct_reg;
`endif
        if (key_valid) begin
            case (state_reg)
                IDLE: begin
                    if (key_byte == BREAK_PREFIX)    state_next = BRK;
                    else if (key_byte == EXT_PREFIX) state_next = EXT;
                    else if (key_mapped)             make_ev    = 1'b1;
`ifdef OCTAVE_SHIFT_EN
                    else if (key_byte == 8'h1A) begin
                        if (oct_reg == 2'b01)      oct_next = 2'b00;
                        else if (oct_reg == 2'b00) oct_next = 2'b11;
                    end else if (key_byte == 8'h22) begin
                        if (oct_reg == 2'b11)      oct_next = 2'b00;
                        else if (oct_reg == 2'b00) oct_next = 2'b01;
                    end
`endif
                end
                BRK: begin
                    state_next = IDLE;
                    if (is_prefix)       err_next = 1'b1;
                    else if (key_mapped) brk_ev   = 1'b1;
                end
                EXT: begin
                    if (key_byte == BREAK_PREFIX) begin
                        state_next = EXT_BRK;
                    end else begin
                        state_next = IDLE;
                        if (key_byte == EXT_PREFIX) err_next = 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    if (is_prefix) err_next = 1'b1;
                end
            endcase
        end

        // A repeated make of a held key changes nothing.
        if (make_ev && !mask_reg[key_idx]) begin
            mask_next[key_idx] = 1'b1;
            idx_next           = key_idx;
        end
        // Releasing the sounding key falls back to the highest held key.
        // When the mask empties, the index holds its last value.
        if (brk_ev && mask_reg[key_idx]) begin
            mask_next[key_idx] = 1'b0;
            if (key_idx == note_idx && |mask_next) begin
                idx_next = highest_held(mask_next);
            end
        end

        on_next = |mask_next;
        hp_next = '0;
        if (on_next) begin
`ifdef OCTAVE_SHIFT_EN
            case (oct_next)
                2'b11:   hp_next = base_hp(idx_next) << 1;
                2'b01:   hp_next = base_hp(idx_next) >> 1;
                default: hp_next = base_hp(idx_next);
            endcase
`else
            hp_next = base_hp(idx_next);
`endif
        end
    end

    // State, mask and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            mask_reg    <= '0;
            note_on     <= 1'b0;
            note_idx    <= 3'd0;
            half_period <= '0;
            key_err     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mask_reg    <= mask_next;
            note_on     <= on_next;
            note_idx    <= idx_next;
            half_period <= hp_next;
            key_err     <= err_next;
        end
    end

`ifdef OCTAVE_SHIFT_EN
    // Octave offset register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) oct_reg <= 2'b00;
        else     oct_reg <= oct_next;
    end
`endif

endmodule

// File: tb/tb_keycode_note_decoder.sv
// Directed testbench for keycode_note_decoder. Expected outputs are pushed to
// a scoreboard queue as each byte is driven. They are popped and compared once
// the registered outputs update. Build with OCTAVE_SHIFT_EN defined to also
// exercise octave shifting.
module tb_keycode_note_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [7:0]  key_byte;
    logic [19:0] half_period;
    logic        note_on;
    logic [2:0]  note_idx;
    logic        key_err;

    typedef struct packed {
        logic        on;
        logic [2:0]  idx;
        logic [19:0] hp;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   txn      = 0;

    keycode_note_decoder #(.COUNT_W(20), .NUM_KEYS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_byte   (key_byte),
        .half_period(half_period),
        .note_on    (note_on),
        .note_idx   (note_idx),
        .key_err    (key_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic on, input logic [2:0] idx, input logic [19:0] hp, input logic err);
        exp_t e;
        e = '{on: on, idx: idx, hp: hp, err: err};
        sb.push_back(e);
    endtask

    task automatic compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".note_on"},     32'(note_on),     32'(e.on));
            check({tag, ".note_idx"},    32'(note_idx),    32'(e.idx));
            check({tag, ".half_period"}, 32'(half_period), 32'(e.hp));
            check({tag, ".key_err"},     32'(key_err),     32'(e.err));
            $display("txn %0d %s: on=%0d idx=%0d hp=%0d err=%0d", txn, tag,
                     note_on, note_idx, half_period, key_err);
        end
        txn++;
    endtask

    // Drive one byte, or an idle cycle when v is 0, then compare the
    // registered result one cycle later.
    task automatic step(input logic v, input logic [7:0] b, input logic on,
                        input logic [2:0] idx, input logic [19:0] hp, input logic err);
        string tag;
        @(negedge clk);
        key_valid = v;
        key_byte  = b;
        push(on, idx, hp, err);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        tag = v ? $sformatf("byte_%h", b) : "idle";
        compare(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        push(1'b0, 3'd0, 20'd0, 1'b0);
        compare("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key_byte  = 8'h00;
        #12;
        push(1'b0, 3'd0, 20'd0, 1'b0);
        compare("reset_init");
        @(negedge clk);
        rst = 1'b0;

        // Basic make, last-pressed priority, break back to the earlier key.
        step(1, 8'h1C, 1, 3'd0, 20'd191109, 0);
        step(1, 8'h33, 1, 3'd5, 20'd113636, 0);
        step(1, 8'hF0, 1, 3'd5, 20'd113636, 0);
        step(1, 8'h33, 1, 3'd0, 20'd191109, 0);
        step(1, 8'hF0, 1, 3'd0, 20'd191109, 0);
        step(1, 8'h1C, 0, 3'd0, 20'd0,      0);

        // Typematic repeat of a held key changes nothing.
        step(1, 8'h23, 1, 3'd2, 20'd151685, 0);
        step(1, 8'h23, 1, 3'd2, 20'd151685, 0);
        step(1, 8'h23, 1, 3'd2, 20'd151685, 0);
        step(1, 8'hF0, 1, 3'd2, 20'd151685, 0);
        step(1, 8'h23, 0, 3'd2, 20'd0,      0);

        // Extended make and break are ignored and leave the mask empty.
        step(1, 8'hE0, 0, 3'd2, 20'd0, 0);
        step(1, 8'h1C, 0, 3'd2, 20'd0, 0);
        step(1, 8'hE0, 0, 3'd2, 20'd0, 0);
        step(1, 8'hF0, 0, 3'd2, 20'd0, 0);
        step(1, 8'h1C, 0, 3'd2, 20'd0, 0);
        step(1, 8'h42, 1, 3'd7, 20'd95556, 0);
        step(1, 8'hF0, 1, 3'd7, 20'd95556, 0);
        step(1, 8'h42, 0, 3'd7, 20'd0,     0);

        // F0 F0 raises a one-cycle error, and the FSM returns to IDLE.
        step(1, 8'hF0, 0, 3'd7, 20'd0, 0);
        step(1, 8'hF0, 0, 3'd7, 20'd0, 1);
        step(0, 8'h00, 0, 3'd7, 20'd0, 0);
        step(1, 8'h1C, 1, 3'd0, 20'd191109, 0);
        step(1, 8'hF0, 1, 3'd0, 20'd191109, 0);
        step(1, 8'h1C, 0, 3'd0, 20'd0,      0);

        // E0 E0 and E0 F0 E0 are malformed.
        step(1, 8'hE0, 0, 3'd0, 20'd0, 0);
        step(1, 8'hE0, 0, 3'd0, 20'd0, 1);
        step(1, 8'hE0, 0, 3'd0, 20'd0, 0);
        step(1, 8'hF0, 0, 3'd0, 20'd0, 0);
        step(1, 8'hE0, 0, 3'd0, 20'd0, 1);

        // Breaking a non-current key keeps the current note.
        step(1, 8'h1C, 1, 3'd0, 20'd191109, 0);
        step(1, 8'h42, 1, 3'd7, 20'd95556,  0);
        step(1, 8'hF0, 1, 3'd7, 20'd95556,  0);
        step(1, 8'h1C, 1, 3'd7, 20'd95556,  0);
        step(1, 8'hF0, 1, 3'd7, 20'd95556,  0);
        step(1, 8'h1C, 1, 3'd7, 20'd95556,  0);
        step(1, 8'hF0, 1, 3'd7, 20'd95556,  0);
        step(1, 8'h42, 0, 3'd7, 20'd0,      0);

        // Breaking the current key falls back to the highest held index.
        step(1, 8'h1B, 1, 3'd1, 20'd170265, 0);
        step(1, 8'h3B, 1, 3'd6, 20'd101238, 0);
        step(1, 8'h2B, 1, 3'd3, 20'd143172, 0);
        step(1, 8'hF0, 1, 3'd3, 20'd143172, 0);
        step(1, 8'h2B, 1, 3'd6, 20'd101238, 0);
        step(1, 8'hF0, 1, 3'd6, 20'd101238, 0);
        step(1, 8'h3B, 1, 3'd1, 20'd170265, 0);
        step(1, 8'hF0, 1, 3'd1, 20'd170265, 0);
        step(1, 8'h1B, 0, 3'd1, 20'd0,      0);

`ifndef OCTAVE_SHIFT_EN
        // Without octave shifting, Z and X are ordinary unmapped codes.
        step(1, 8'h1A, 0, 3'd1, 20'd0, 0);
        step(1, 8'h22, 0, 3'd1, 20'd0, 0);
`endif

        // Reset after F0 discards the pending break prefix.
        step(1, 8'h33, 1, 3'd5, 20'd113636, 0);
        step(1, 8'hF0, 1, 3'd5, 20'd113636, 0);
        do_reset();
        step(1, 8'h42, 1, 3'd7, 20'd95556, 0);

`ifdef OCTAVE_SHIFT_EN
        // The octave shift applies to the sounding note and saturates at both ends.
        do_reset();
        step(1, 8'h1C, 1, 3'd0, 20'd191109, 0);
        step(1, 8'h22, 1, 3'd0, 20'd95554,  0);
        step(1, 8'h22, 1, 3'd0, 20'd95554,  0);
        step(1, 8'h1A, 1, 3'd0, 20'd191109, 0);
        step(1, 8'h1A, 1, 3'd0, 20'd382218, 0);
        step(1, 8'h1A, 1, 3'd0, 20'd382218, 0);
        step(1, 8'hF0, 1, 3'd0, 20'd382218, 0);
        step(1, 8'h1A, 1, 3'd0, 20'd382218, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keycode_note_decoder.md
KEYCODE_NOTE_DECODER -- requirements
Module: keycode_note_decoder

Interface
REQ-001 Parameter: COUNT_W, 20, width of half_period output.
REQ-002 Parameter: NUM_KEYS, 8, number of mapped note keys (fixed at 8; other values unsupported).
REQ-003 clk  input  1  system clock (100 MHz); all logic on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 key_valid  input  1  one-cycle strobe; key_byte holds a new PS/2 scan byte this cycle.
REQ-006 key_byte  input  8  PS/2 set-2 scan byte (make code, 0xF0 break prefix, 0xE0 extended prefix).
REQ-007 half_period  output  COUNT_W  clk cycles per speaker half-period for the current note; 0 when silent.
REQ-008 note_on  output  1  high while at least one mapped key is held.
REQ-009 note_idx  output  3  index of current note (0=C4 .. 7=C5); holds last value when silent.
REQ-010 key_err  output  1  one-cycle pulse on malformed prefix sequence.

Function
REQ-011 Key map (code -> idx, half_period): 1C->0,191109; 1B->1,170265; 23->2,151685; 2B->3,143172; 34->4,127550; 33->5,113636; 3B->6,101238; 42->7,95556.
REQ-012 Decoder FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen); only key_valid cycles advance it.
REQ-013 IDLE: F0 -> BRK; E0 -> EXT; mapped code -> make event, stay IDLE; any other code -> ignored, stay IDLE.
REQ-014 BRK: mapped code -> break event, go IDLE; unmapped code -> ignored, go IDLE; F0 or E0 -> key_err pulse, go IDLE.
REQ-015 EXT: F0 -> EXT_BRK; E0 -> key_err, go IDLE; any other byte -> ignored, go IDLE.
REQ-016 EXT_BRK: any byte other than F0/E0 -> ignored, go IDLE; F0 or E0 -> key_err, go IDLE.
REQ-017 Held-key mask (8 bits): make event sets bit idx; break event clears bit idx.
REQ-018 Make event of a key not held: key becomes current note (last-pressed priority).
REQ-019 Make event of a key already held (typematic repeat): no output change.
REQ-020 Break event of current note with other keys held: current note becomes highest-index held key.
REQ-021 Break event of a non-current key: current note unchanged; break of a key not held: no effect.
REQ-022 Mask becomes empty: note_on=0, half_period=0, note_idx holds.
REQ-023 All outputs registered; latency: outputs reflect an event on the cycle after the key_valid cycle carrying the final byte.
REQ-024 key_err asserted exactly one cycle, same cycle outputs would update; mask unchanged by errors.
REQ-025 key_valid low: FSM, mask and outputs hold.

Reset
REQ-026 rst high asynchronously forces: FSM=IDLE, mask=0, note_on=0, half_period=0, note_idx=0, key_err=0, octave offset=0.
REQ-027 Reset mid-sequence (e.g. after F0) discards the pending prefix; first byte after release decoded from IDLE.

Configuration
REQ-028 Macro OCTAVE_SHIFT_EN defined: codes 1A (Z) and 22 (X) in IDLE decrement/increment octave offset, range -1..+1, saturating; their break codes ignored.
REQ-029 With OCTAVE_SHIFT_EN: half_period = table value <<1 (offset -1), unchanged (0), >>1 (offset +1); applied immediately to a sounding note, next cycle.
REQ-030 Without OCTAVE_SHIFT_EN: 1A and 22 are unmapped (ignored), offset logic absent, half_period = table value.

Verification
REQ-031 Reset, then key_valid bytes 1C -> next cycle note_on=1, note_idx=0, half_period=191109.
REQ-032 Bytes 1C, 33, F0 33 -> after 33: idx=5, 113636; after F0 33: idx=0, 191109; then F0 1C -> note_on=0, half_period=0, note_idx=0.
REQ-033 Bytes 23, 23, 23 (typematic) then F0 23 -> idx=2 steady 151685, then silent; no key_err.
REQ-034 Bytes E0 1C, then E0 F0 1C -> no output change, mask empty; bytes F0 F0 -> key_err one-cycle pulse, FSM IDLE.
REQ-035 Bytes F0, assert rst, release, then 42 -> note_on=1, idx=7, half_period=95556 (prefix discarded).
REQ-036 With OCTAVE_SHIFT_EN: 1C, 22, 22 -> 191109, 95554, 95554 (saturated); 1A, 1A, 1A -> 191109, 382218, 382218.
